// File: rtl/xorpuf_pkg.sv
// Shared types and constants for the XOR arbiter-PUF controller.
package xorpuf_pkg;

    localparam int N_DEF = 16;
    localparam int K_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        FIRE,
        WAIT,
        CAPTURE,
        RESP,
        RELAX
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/xorpuf_if.sv
// Request/response and PUF-array signal bundle; the slave modport is the controller side.
// resp_unstable exists only when XORPUF_MAJ_EN is defined.
interface xorpuf_if
    import xorpuf_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_chal;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_bit;
    logic [K-1:0] resp_bits;
    logic         resp_timeout;
`ifdef XORPUF_MAJ_EN
    logic         resp_unstable;
`endif
    logic [N-1:0] puf_c;
    logic         puf_tig;
    logic         puf_ready;
    logic [K-1:0] puf_bit_a;
    logic         puf_bit;

    modport slave (
        input  req_valid, req_chal, resp_ready, puf_ready, puf_bit_a, puf_bit,
        output req_ready, resp_valid, resp_bit, resp_bits, resp_timeout, puf_c, puf_tig
`ifdef XORPUF_MAJ_EN
        , output resp_unstable
`endif
    );

    modport master (
        output req_valid, req_chal, resp_ready, puf_ready, puf_bit_a, puf_bit,
        input  req_ready, resp_valid, resp_bit, resp_bits, resp_timeout, puf_c, puf_tig
`ifdef XORPUF_MAJ_EN
        , input resp_unstable
`endif
    );

endinterface

// File: rtl/xorpuf_sync2.sv
// Two-flop synchronizer for the asynchronous array-ready indication.
module xorpuf_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/xorpuf_ctrl.sv
// Sequencer for the XOR arbiter-PUF array: settle, fire, wait/timeout, capture, respond, relax.
// XORPUF_MAJ_EN: evaluate each challenge VOTES times and return per-APUF majority plus resp_unstable.
module xorpuf_ctrl
    import xorpuf_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int K           = K_DEF,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255
`ifdef XORPUF_MAJ_EN
    , parameter int VOTES     = 5
`endif
) (
    input logic     clk,
    input logic     rst_n,
    xorpuf_if.slave bus
);
    // One counter serves settle, wait and relax, so it must cover the larger limit.
    localparam int CMAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CW   = clog2(CMAX + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          ready_s, settle_hit, tmo_hit, tmo_fire, last_eval, more;
    logic [N-1:0]  chal_q;
    logic [K-1:0]  bits_q, cap_bits;
    logic          tig_q, bit_q, tmo_q, cap_bit;

    xorpuf_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(bus.puf_ready), .q(ready_s));

    assign settle_hit = (cnt == CW'(SETTLE_CYC - 1));
    assign tmo_hit    = (cnt == CW'(TIMEOUT_CYC - 1));
    assign tmo_fire   = (state == WAIT) && !ready_s && tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (bus.req_valid) state_nx = SETTLE;
            end
            SETTLE: if (settle_hit) begin
                state_nx = FIRE;
                cnt_nx   = '0;
            end
            FIRE: begin
                state_nx = WAIT;
                cnt_nx   = '0;
            end
            // ready is checked first so it wins a tie with the timeout
            WAIT: begin
                if (ready_s)      state_nx = CAPTURE;
                else if (tmo_hit) state_nx = RESP;
            end
            CAPTURE: begin
                state_nx = last_eval ? RESP : RELAX;
                cnt_nx   = '0;
            end
            RESP: begin
                cnt_nx = '0;
                if (bus.resp_ready) state_nx = RELAX;
            end
            RELAX: if (settle_hit) begin
                state_nx = more ? SETTLE : IDLE;
                cnt_nx   = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chal_q <= '0;
            tig_q  <= 1'b0;
            bits_q <= '0;
            bit_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    chal_q <= bus.req_chal;
                    tmo_q  <= 1'b0;
                end
                SETTLE: if (settle_hit) tig_q <= 1'b1;
                WAIT: if (tmo_fire) begin
                    tmo_q  <= 1'b1;
                    bits_q <= '0;
                    bit_q  <= 1'b0;
                end
                CAPTURE: begin
                    if (last_eval) begin
                        bits_q <= cap_bits;
                        bit_q  <= cap_bit;
                    end else begin
                        tig_q  <= 1'b0;
                    end
                end
                RESP: if (bus.resp_ready) tig_q <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef XORPUF_MAJ_EN
    logic [K-1:0][3:0] votes, tally;
    logic [K-1:0]      maj;
    logic              mixed, uns_q;
    logic [3:0]        ev;

    always_comb begin
        tally = votes;
        maj   = '0;
        mixed = 1'b0;
        for (int i = 0; i < K; i++) begin
            tally[i] = votes[i] + 4'(bus.puf_bit_a[i]);
            maj[i]   = (tally[i] > 4'(VOTES / 2));
            if (tally[i] != 4'd0 && tally[i] != 4'(VOTES)) mixed = 1'b1;
        end
    end

    // ev counts finished evaluations; nonzero means RELAX must loop back to SETTLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            votes <= '0;
            ev    <= '0;
            uns_q <= 1'b0;
        end else if (state == IDLE && bus.req_valid) begin
            votes <= '0;
            ev    <= '0;
            uns_q <= 1'b0;
        end else if (tmo_fire) begin
            ev    <= '0;
            uns_q <= 1'b0;
        end else if (state == CAPTURE) begin
            if (last_eval) begin
                ev    <= '0;
                uns_q <= mixed;
            end else begin
                votes <= tally;
                ev    <= ev + 1'b1;
            end
        end
    end

    assign last_eval         = (ev == 4'(VOTES - 1));
    assign more              = (ev != 4'd0);
    assign cap_bits          = maj;
    assign cap_bit           = ^maj;
    assign bus.resp_unstable = uns_q;
`else
    assign last_eval = 1'b1;
    assign more      = 1'b0;
    assign cap_bits  = bus.puf_bit_a;
    assign cap_bit   = bus.puf_bit;
`endif

    assign bus.req_ready    = (state == IDLE);
    assign bus.resp_valid   = (state == RESP);
    assign bus.resp_bit     = bit_q;
    assign bus.resp_bits    = bits_q;
    assign bus.resp_timeout = tmo_q;
    assign bus.puf_c        = chal_q;
    assign bus.puf_tig      = tig_q;

endmodule

// File: tb/tb_xorpuf_ctrl.sv
// Bench for xorpuf_ctrl: table vectors, random transactions against a latency/response model, corner sequences.
module tb_xorpuf_ctrl;
    import xorpuf_pkg::*;

    localparam int N   = 16;
    localparam int K   = 8;
    localparam int S   = 4;
    localparam int TMO = 255;
`ifdef XORPUF_MAJ_EN
    localparam int VOTES = 5;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xorpuf_if #(.N(N), .K(K)) bus ();

    xorpuf_ctrl #(
        .N(N), .K(K), .SETTLE_CYC(S), .TIMEOUT_CYC(TMO)
`ifdef XORPUF_MAJ_EN
        , .VOTES(VOTES)
`endif
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [N-1:0] chal;
        int           dly;
        bit           never;
        logic [K-1:0] bits;
        int           hold;
        logic [K-1:0] e_bits;
        logic         e_bit;
        logic         e_tmo;
        logic         e_uns;
        int           e_lat;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // array model configuration
    int           m_delay = 0;
    bit           m_never = 1'b0;
    logic [K-1:0] m_bits = '0;
    logic [K-1:0] m_seq[$];
    int           pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Array model: ready rises D cycles after the trigger rises; bits chosen per trigger pulse.
    initial begin
        int           hi;
        logic         tig_d;
        logic [K-1:0] cur;
        hi = 0; tig_d = 1'b0; cur = '0;
        bus.puf_ready = 1'b0;
        bus.puf_bit_a = '0;
        bus.puf_bit   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.puf_tig === 1'b1 && !tig_d) begin
                pulses++;
                hi  = 0;
                cur = (m_seq.size() > 0) ? m_seq.pop_front() : m_bits;
            end
            tig_d = (bus.puf_tig === 1'b1);
            if (tig_d) hi++; else hi = 0;
            bus.puf_ready = tig_d && !m_never && (hi >= m_delay + 1);
            bus.puf_bit_a = cur;
            bus.puf_bit   = ^cur;
        end
    end

    function automatic vec_t ref_vec(logic [N-1:0] chal, int dly, bit never, logic [K-1:0] bits, int hold);
        vec_t v;
        v.chal   = chal;
        v.dly    = dly;
        v.never  = never;
        v.bits   = bits;
        v.hold   = hold;
        v.e_tmo  = never;
        v.e_bits = never ? '0 : bits;
        v.e_bit  = ($countones(v.e_bits) % 2) == 1;
        v.e_uns  = 1'b0;
        v.e_lat  = never ? S + 1 + TMO : S + 1 + dly + 2 + 1;
        return v;
    endfunction

    function automatic int lat_total(vec_t v);
`ifdef XORPUF_MAJ_EN
        if (!v.e_tmo) return v.e_lat + (VOTES - 1) * (v.e_lat + S);
`endif
        return v.e_lat;
    endfunction

    function automatic int pulses_exp(vec_t v);
`ifdef XORPUF_MAJ_EN
        if (!v.e_tmo) return VOTES;
`endif
        return 1;
    endfunction

    task automatic do_txn(input string tag, input vec_t v, input bit chain, input logic [N-1:0] nxt);
        int t, lat;
        bit c_moved;
        m_delay = v.dly;
        m_never = v.never;
        m_bits  = v.bits;
        pulses  = 0;
        bus.req_chal  = v.chal;
        bus.req_valid = 1'b1;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk({tag, ".req_ready_wait"}, bus.req_ready, 1'b1);
        @(posedge clk); #1;
        if (chain) bus.req_chal = nxt; else bus.req_valid = 1'b0;
        if (v.hold < 0) bus.resp_ready = 1'b1;
        chk({tag, ".accepted"}, {bus.req_ready, bus.resp_timeout}, 2'b00);
        chk({tag, ".puf_c"}, bus.puf_c, v.chal);
        lat = 0;
        c_moved = 1'b0;
        while (bus.resp_valid !== 1'b1 && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            if (bus.puf_c !== v.chal) c_moved = 1'b1;
        end
        chk({tag, ".latency"}, lat, lat_total(v));
        chk({tag, ".puf_c_stable"}, c_moved, 1'b0);
        chk({tag, ".resp"}, {bus.resp_timeout, bus.resp_bit, bus.resp_bits}, {v.e_tmo, v.e_bit, v.e_bits});
        chk({tag, ".tig_in_resp"}, bus.puf_tig, 1'b1);
        chk({tag, ".pulses"}, pulses, pulses_exp(v));
`ifdef XORPUF_MAJ_EN
        chk({tag, ".unstable"}, bus.resp_unstable, v.e_uns);
`endif
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold"}, {bus.resp_valid, bus.puf_tig, bus.req_ready, bus.resp_timeout, bus.resp_bit, bus.resp_bits},
                {1'b1, 1'b1, 1'b0, v.e_tmo, v.e_bit, v.e_bits});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < S; i++) begin
            chk({tag, ".relax"}, {bus.resp_valid, bus.puf_tig, bus.req_ready}, 3'b000);
            @(posedge clk); #1;
        end
        chk({tag, ".idle_after_relax"}, bus.req_ready, 1'b1);
    endtask

    vec_t tbl[5];

    initial begin
        vec_t v, v2;
        tbl[0] = '{16'hA5A5, 3, 1'b0, 8'h3C, 10, 8'h3C, 1'b0, 1'b0, 1'b0, 11};
        tbl[1] = '{16'h0001, 0, 1'b0, 8'hFF,  0, 8'hFF, 1'b0, 1'b0, 1'b0,  8};
        tbl[2] = '{16'h1234, 0, 1'b1, 8'hAA,  1, 8'h00, 1'b0, 1'b1, 1'b0, 260};
        tbl[3] = '{16'hFFFF, 6, 1'b0, 8'h01, -1, 8'h01, 1'b1, 1'b0, 1'b0, 14};
        tbl[4] = '{16'h8000, 1, 1'b0, 8'h80,  2, 8'h80, 1'b1, 1'b0, 1'b0,  9};

        bus.req_valid  = 1'b0;
        bus.req_chal   = '0;
        bus.resp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.req_ready, bus.resp_valid, bus.resp_bit, bus.resp_bits, bus.resp_timeout, bus.puf_c, bus.puf_tig},
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) do_txn($sformatf("tbl%0d", i), tbl[i], 1'b0, '0);

        for (int i = 0; i < 16; i++) begin
            v = ref_vec(N'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
                        K'($urandom), int'($urandom_range(0, 3)));
            do_txn($sformatf("rnd%0d", i), v, 1'b0, '0);
        end

        // reset while waiting for ready aborts the evaluation
        m_never = 1'b1;
        bus.req_chal  = 16'h5A5A;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (S + 4) @(posedge clk);
        #1;
        chk("rst_mid.tig_before", {bus.puf_tig, bus.req_ready}, 2'b10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid.after", {bus.puf_tig, bus.req_ready, bus.resp_valid, bus.resp_bits, bus.resp_bit, bus.resp_timeout, bus.puf_c},
            {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn("post_rst", tbl[0], 1'b0, '0);

        // back-to-back with req_valid held through the first transaction
        v  = ref_vec(16'h0001, 2, 1'b0, 8'h5A, 0);
        v2 = ref_vec(16'hFFFF, 1, 1'b0, 8'hC3, 2);
        do_txn("b2b0", v, 1'b1, 16'hFFFF);
        do_txn("b2b1", v2, 1'b0, '0);

`ifdef XORPUF_MAJ_EN
        m_seq.push_back(8'h01);
        m_seq.push_back(8'h01);
        m_seq.push_back(8'h00);
        m_seq.push_back(8'h01);
        m_seq.push_back(8'h00);
        v = '{16'hC0DE, 2, 1'b0, 8'h00, 0, 8'h01, 1'b1, 1'b0, 1'b1, 10};
        do_txn("majority", v, 1'b0, '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
